// File: rtl/ibus_line_responder_if.sv
// Fetch-side instruction bus between the fetch stage (master) and the line responder (slave).
interface ibus_line_responder_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       data;

    modport master (output req_valid, req_addr, input addr_ok, data_ok, data);
    modport slave  (input req_valid, req_addr, output addr_ok, data_ok, data);
endinterface

// File: rtl/ibus_line_responder.sv
// Instruction bus responder with a single-line buffer. Hits answer in one cycle and misses
// burst-fill the whole line from the 64-bit memory port.
// Optional hit/miss counters are enabled with the macro IBUS_RESP_STATS_EN.
module ibus_line_responder #(
    parameter int unsigned LINE_BEATS = 4,
    parameter int unsigned ADDR_W     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    ibus_line_responder_if.slave  ibus,
    input  logic                  flush,
    output logic                  mreq_valid,
    output logic [ADDR_W-1:0]     mreq_addr,
    input  logic                  mreq_ready,
    input  logic                  mresp_valid,
    input  logic [63:0]           mresp_data,
    input  logic                  mresp_last,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);
    localparam int unsigned OFF_W  = $clog2(8 * LINE_BEATS);
    localparam int unsigned BEAT_W = $clog2(LINE_BEATS);
    localparam int unsigned TAG_W  = ADDR_W - OFF_W;

    typedef enum logic [1:0] {StIdle, StResp, StFillReq, StFillData} state_t;

    state_t            state_q;
    logic              started_q;
    logic              buf_valid_q;
    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  line_q;
    logic [BEAT_W-1:0] beat_idx_q;
    logic              drop_q;
    logic              after_fill_q;
    logic              data_ok_q;
    logic [31:0]       data_q;
    logic              mreq_valid_q;
    logic [63:0]       line_mem [LINE_BEATS];

    logic [TAG_W-1:0]  req_tag;
    logic [BEAT_W-1:0] req_beat;
    logic [63:0]       sel_beat;
    logic [31:0]       sel_word;
    logic              hit;
    logic              accept;

    assign req_tag  = ibus.req_addr[ADDR_W-1:OFF_W];
    assign req_beat = ibus.req_addr[OFF_W-1:3];
    assign sel_beat = line_mem[req_beat];
    assign sel_word = ibus.req_addr[2] ? sel_beat[63:32] : sel_beat[31:0];
    assign hit      = buf_valid_q & (tag_q == req_tag) & ~flush;
    // started_q keeps every output quiet during the first cycle after reset release.
    assign accept   = (state_q == StIdle) & started_q & ibus.req_valid;

    assign ibus.addr_ok = accept;
    assign ibus.data_ok = data_ok_q;
    assign ibus.data    = data_q;
    assign mreq_valid   = mreq_valid_q;
    assign mreq_addr    = {line_q, {OFF_W{1'b0}}};

    // Byte offset within a word is not used; fetch handles misalignment.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^ibus.req_addr[1:0];

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            started_q    <= 1'b0;
            buf_valid_q  <= 1'b0;
            tag_q        <= '0;
            line_q       <= '0;
            beat_idx_q   <= '0;
            drop_q       <= 1'b0;
            after_fill_q <= 1'b0;
            data_ok_q    <= 1'b0;
            data_q       <= '0;
            mreq_valid_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
            data_ok_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (flush) buf_valid_q <= 1'b0;
                    if (accept) begin
                        after_fill_q <= 1'b0;
                        if (hit) begin
                            state_q   <= StResp;
                            data_ok_q <= 1'b1;
                            data_q    <= sel_word;
                        end else begin
                            state_q      <= StFillReq;
                            line_q       <= req_tag;
                            mreq_valid_q <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    if (flush) buf_valid_q <= 1'b0;
                    state_q <= StIdle;
                end
                StFillReq: begin
                    if (flush) drop_q <= 1'b1;
                    if (mreq_ready) begin
                        mreq_valid_q <= 1'b0;
                        beat_idx_q   <= '0;
                        state_q      <= StFillData;
                    end
                end
                StFillData: begin
                    if (flush) drop_q <= 1'b1;
                    if (mresp_valid) begin
                        beat_idx_q <= beat_idx_q + BEAT_W'(1);
                        // The last flag ends the burst even if fewer beats arrived.
                        if (mresp_last) begin
                            tag_q        <= line_q;
                            buf_valid_q  <= ~drop_q & ~flush;
                            drop_q       <= 1'b0;
                            after_fill_q <= 1'b1;
                            state_q      <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Line storage; validity is tracked by buf_valid_q so the data needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == StFillData && mresp_valid) line_mem[beat_idx_q] <= mresp_data;
    end

`ifdef IBUS_RESP_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating counters; the re-evaluation right after a fill is not a real hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept) begin
            if (hit && !after_fill_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_after_fill;
    assign unused_after_fill = after_fill_q;
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_ibus_line_responder.sv
// Self-checking bench for ibus_line_responder: vector table plus multi-cycle sequences,
// with a behavioural memory responder and a response scoreboard.
module tb_ibus_line_responder;
    localparam int unsigned LINE_BEATS = 4;
`ifdef IBUS_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        flush;
    logic        mreq_valid;
    logic [63:0] mreq_addr;
    logic        mreq_ready;
    logic        mresp_valid;
    logic [63:0] mresp_data;
    logic        mresp_last;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    ibus_line_responder_if #(.ADDR_W(64)) ibus ();

    ibus_line_responder #(.LINE_BEATS(LINE_BEATS), .ADDR_W(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .ibus        (ibus),
        .flush       (flush),
        .mreq_valid  (mreq_valid),
        .mreq_addr   (mreq_addr),
        .mreq_ready  (mreq_ready),
        .mresp_valid (mresp_valid),
        .mresp_data  (mresp_data),
        .mresp_last  (mresp_last),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    typedef struct {
        logic [63:0] addr;
        logic        fl;
        logic        stray;
        logic        hit;
        logic [31:0] data;
    } vec_t;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    int          beats_sent = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    bit          stray_en = 1'b0;
    logic [63:0] fill_q [$];
    logic [31:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] aw;
        aw = {a[63:2], 2'b00};
        if (aw == 64'h8000_0000) return 32'h0000_0093;
        if (aw == 64'h8000_0004) return 32'h0000_0013;
        return {16'hC0DE ^ aw[31:16], aw[15:0]};
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return {a[63:5], 5'b0};
    endfunction

    task automatic check_cnt(input string name);
        check({name, "_hit_cnt"}, 64'(hit_cnt), STATS ? 64'(exp_hits) : 64'd0);
        check({name, "_miss_cnt"}, 64'(miss_cnt), STATS ? 64'(exp_misses) : 64'd0);
    endtask

    // Memory model: accepts one fill, returns LINE_BEATS ascending beats, aborts on reset.
    initial begin
        int          mstate;
        logic [63:0] base;
        logic [63:0] off;
        mstate = 0;
        base = '0;
        mreq_ready = 1'b0;
        mresp_valid = 1'b0;
        mresp_data = '0;
        mresp_last = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mreq_ready = 1'b0;
            mresp_valid = 1'b0;
            mresp_last = 1'b0;
            mresp_data = '0;
            if (!reset) begin
                mstate = 0;
            end else if (mstate == 0) begin
                if (mreq_valid) begin
                    mreq_ready = 1'b1;
                    base = mreq_addr;
                    fill_q.push_back(mreq_addr);
                    beats_sent = 0;
                    mstate = 1;
                end else if (stray_en) begin
                    mresp_valid = 1'b1;
                    mresp_last = 1'b1;
                    mresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
                end
            end else begin
                off = 64'(beats_sent) << 3;
                mresp_valid = 1'b1;
                mresp_data = {mem_word(base + off + 64'd4), mem_word(base + off)};
                if (beats_sent == LINE_BEATS - 1) begin
                    mresp_last = 1'b1;
                    last_cyc = cyc;
                    mstate = 0;
                end
                beats_sent++;
            end
        end
    end

    // Scoreboard: every data_ok must match the oldest outstanding expectation.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (ibus.data_ok) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_data_ok: got data 0x%0h, expected no response",
                             ibus.data);
                end else begin
                    exp = exp_q.pop_front();
                    check("resp_data", 64'(ibus.data), 64'(exp));
                end
            end
        end
    end

    task automatic do_req(input vec_t v, input string name);
        int n;
        int dcyc;
        bit got;
        if (v.stray) begin
            @(posedge clk);
            #2 stray_en = 1'b1;
            repeat (3) @(posedge clk);
            #2 stray_en = 1'b0;
        end
        fill_q.delete();
        exp_q.push_back(v.data);
        @(posedge clk);
        #1;
        ibus.req_valid = 1'b1;
        ibus.req_addr = v.addr;
        flush = v.fl;
        n = 0;
        dcyc = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) check({name, "_addr_ok"}, 64'(ibus.addr_ok), 64'd1);
            if (n == 2) flush = 1'b0;
            if (ibus.data_ok) begin
                got = 1'b1;
                dcyc = cyc;
            end
        end
        flush = 1'b0;
        check({name, "_responded"}, 64'(got), 64'd1);
        if (v.hit) begin
            check({name, "_hit_latency"}, 64'(n), 64'd2);
            check({name, "_no_fill"}, 64'(fill_q.size()), 64'd0);
        end else begin
            check({name, "_fill_count"}, 64'(fill_q.size()), 64'd1);
            check({name, "_fill_addr"}, fill_q.size() > 0 ? fill_q[0] : '1, line_of(v.addr));
            check({name, "_miss_latency"}, 64'(dcyc - last_cyc), 64'd2);
        end
        @(posedge clk);
        #1;
        ibus.req_valid = 1'b0;
        if (v.hit) exp_hits++;
        else exp_misses++;
        check_cnt(name);
    endtask

    task automatic wait_resp(input string name);
        int n;
        n = 0;
        while (!ibus.data_ok && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_responded"}, 64'(ibus.data_ok), 64'd1);
    endtask

    task automatic wait_beats(input int beats, input string name);
        int n;
        n = 0;
        while (!(fill_q.size() == 1 && beats_sent == beats) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_beat_reached"}, 64'(beats_sent), 64'(beats));
    endtask

    vec_t vecs [9];
    vec_t tail;

    initial begin
        vecs[0] = '{64'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0093};
        vecs[1] = '{64'h8000_0004, 1'b0, 1'b0, 1'b1, 32'h0000_0013};
        vecs[2] = '{64'h8000_001C, 1'b0, 1'b1, 1'b1, mem_word(64'h8000_001C)};
        vecs[3] = '{64'h8000_0010, 1'b0, 1'b0, 1'b1, mem_word(64'h8000_0010)};
        vecs[4] = '{64'h8000_0020, 1'b0, 1'b0, 1'b0, mem_word(64'h8000_0020)};
        vecs[5] = '{64'h8000_003C, 1'b0, 1'b0, 1'b1, mem_word(64'h8000_003C)};
        vecs[6] = '{64'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0093};
        vecs[7] = '{64'h8000_0002, 1'b0, 1'b0, 1'b1, 32'h0000_0093};
        vecs[8] = '{64'h8000_0004, 1'b1, 1'b0, 1'b0, 32'h0000_0013};

        reset = 1'b0;
        flush = 1'b0;
        ibus.req_valid = 1'b1;
        ibus.req_addr = 64'h8000_0000;
        repeat (3) @(negedge clk);
        check("rst_addr_ok", 64'(ibus.addr_ok), 64'd0);
        check("rst_data_ok", 64'(ibus.data_ok), 64'd0);
        check("rst_data", 64'(ibus.data), 64'd0);
        check("rst_mreq_valid", 64'(mreq_valid), 64'd0);
        check("rst_mreq_addr", mreq_addr, 64'd0);
        check_cnt("rst");
        reset = 1'b1;
        #1;
        check("rel_addr_ok", 64'(ibus.addr_ok), 64'd0);
        check("rel_mreq_valid", 64'(mreq_valid), 64'd0);

        for (int i = 0; i < 9; i++) do_req(vecs[i], $sformatf("vec%0d", i));

        // Flush during beat 1: the fill completes but is dropped, so the held request refills.
        fill_q.delete();
        exp_q.push_back(mem_word(64'h8000_0040));
        @(posedge clk);
        #1;
        ibus.req_valid = 1'b1;
        ibus.req_addr = 64'h8000_0040;
        wait_beats(2, "flush_mid");
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        wait_resp("flush_mid");
        check("flush_mid_fills", 64'(fill_q.size()), 64'd2);
        check("flush_mid_fill1", fill_q.size() > 1 ? fill_q[1] : '1, 64'h8000_0040);
        @(posedge clk);
        #1 ibus.req_valid = 1'b0;
        exp_misses += 2;
        check_cnt("flush_mid");

        // Request redirected during a fill: old fill finishes silently, new line follows.
        fill_q.delete();
        exp_q.push_back(mem_word(64'h8000_0200));
        @(posedge clk);
        #1;
        ibus.req_valid = 1'b1;
        ibus.req_addr = 64'h8000_0100;
        repeat (2) @(posedge clk);
        #1 ibus.req_addr = 64'h8000_0200;
        wait_resp("redirect");
        check("redirect_fills", 64'(fill_q.size()), 64'd2);
        check("redirect_fill0", fill_q.size() > 0 ? fill_q[0] : '1, 64'h8000_0100);
        check("redirect_fill1", fill_q.size() > 1 ? fill_q[1] : '1, 64'h8000_0200);
        @(posedge clk);
        #1 ibus.req_valid = 1'b0;
        exp_misses += 2;
        check_cnt("redirect");

        // Asynchronous reset during beat 2, away from any clock edge.
        fill_q.delete();
        @(posedge clk);
        #1;
        ibus.req_valid = 1'b1;
        ibus.req_addr = 64'h8000_0300;
        wait_beats(3, "areset");
        #1 reset = 1'b0;
        #1;
        check("areset_addr_ok", 64'(ibus.addr_ok), 64'd0);
        check("areset_data_ok", 64'(ibus.data_ok), 64'd0);
        check("areset_data", 64'(ibus.data), 64'd0);
        check("areset_mreq_valid", 64'(mreq_valid), 64'd0);
        check("areset_mreq_addr", mreq_addr, 64'd0);
        exp_hits = 0;
        exp_misses = 0;
        check_cnt("areset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("areset_rel_addr_ok", 64'(ibus.addr_ok), 64'd0);
        tail = '{64'h8000_0304, 1'b0, 1'b0, 1'b0, mem_word(64'h8000_0304)};
        do_req(tail, "after_reset");

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ibus_line_responder.md
Name: ibus_line_responder

Overview:
- Responder end of the instruction bus: accepts ibus_req_t from the fetch stage and returns ibus_resp_t.
- Holds one instruction line in a single-entry buffer. Hits answer in 1 cycle; misses burst-fill the line from a 64-bit backing memory port.
- Sits between fetch and the memory/bus arbiter. Translation happens upstream, so addresses are physical.

Parameters:
- LINE_BEATS, 4, number of 64-bit beats per line (power of 2, ≥2); line bytes = 8*LINE_BEATS.
- ADDR_W, 64, address width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ireq  input  ibus_req_t  fetch request: valid, addr; valid is level-held until data_ok.
- iresp  output  ibus_resp_t  addr_ok, data_ok, data[31:0].
- flush  input  1  invalidate line buffer (fence.i / satp change).
- mreq_valid  output  1  line-fill request to memory.
- mreq_addr  output  ADDR_W  line-aligned fill address.
- mreq_ready  input  1  memory accepts request.
- mresp_valid  input  1  beat valid.
- mresp_data  input  64  beat data, little-endian, ascending address order.
- mresp_last  input  1  final beat of burst.
- hit_cnt  output  32  hit counter (optional feature).
- miss_cnt  output  32  miss counter (optional feature).

Behaviour:
- Reset (reset low, async): state=IDLE, buf_valid=0, tag=0, beat_idx=0, drop=0. All outputs are 0 while reset is low and in the first cycle after release.
- Line tag = addr[ADDR_W-1:log2(8*LINE_BEATS)].
- hit = buf_valid & tag match & ~flush.
- Word select = addr[log2(8*LINE_BEATS)-1:2]. addr[1:0] is ignored; fetch flags misalignment.
- iresp.addr_ok = (state==IDLE) & ireq.valid. This path is combinational.
- State IDLE:
  - ireq.valid & hit → RESP. Latch the selected word.
  - ireq.valid & ~hit → FILL_REQ. Latch the line address.
  - Otherwise stay in IDLE.
- State RESP:
  - data_ok=1 for exactly one cycle; data = latched word.
  - Next state IDLE, even if ireq.valid has dropped.
- State FILL_REQ:
  - mreq_valid=1; mreq_addr = latched line address, held stable.
  - On mreq_ready → FILL_DATA, beat_idx=0.
- State FILL_DATA:
  - On each mresp_valid, write beat[beat_idx] and increment beat_idx modulo LINE_BEATS.
  - On mresp_valid & mresp_last: tag ← latched line; buf_valid ← ~drop & ~flush; drop ← 0; → IDLE.
  - mresp_last terminates the fill regardless of beat_idx.
- Hit latency: data_ok on the cycle after the request is seen in IDLE.
- Miss latency: data_ok 2 cycles after the mresp_last beat (IDLE re-evaluates as a hit, then RESP).
- ireq.valid dropped or addr changed during a fill (branch or flush in fetch): the fill always completes. IDLE then re-evaluates the current request, with no response for the stale address.
- flush:
  - In IDLE or RESP: buf_valid ← 0 next edge. A RESP already in progress still completes.
  - In FILL_REQ or FILL_DATA: drop ← 1; the line is not marked valid at completion.
- flush in the same cycle as a hit in IDLE: treated as a miss.
- mresp_valid outside FILL_DATA is ignored.
- Reset asserted mid-fill: buffer is invalidated immediately. The memory side must discard the burst; stray beats after reset are ignored.
- Single outstanding fill only; mreq_valid is never asserted in IDLE or RESP.

Optional Feature:
- Macro IBUS_RESP_STATS_EN.
  - Defined: hit_cnt increments on each IDLE→RESP transition that is not the first evaluation after a fill. miss_cnt increments on each IDLE→FILL_REQ transition. Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
  - Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Cold miss: reset release, ireq{valid=1, addr=0x80000000}. Expect mreq_valid with mreq_addr=0x80000000. Return 4 beats, beat0=0x0000001300000093, last on beat 3. Expect data_ok with data=0x00000093 two cycles after the last beat; miss_cnt=1.
- Hit sequence: after the cold miss, request 0x80000004 then 0x8000001C. Each gets data_ok 1 cycle after the request is seen; data = upper half of beat0 and upper half of beat3; no mreq_valid; hit_cnt=2.
- Line crossing: request 0x80000020 → new fill with mreq_addr=0x80000020. The old line is replaced; request 0x80000000 afterwards misses again.
- Flush mid-fill: assert flush during beat 1 of a fill for 0x80000040. The fill completes with buf_valid=0; the still-held request to 0x80000040 causes a second fill.
- Request withdrawn: ireq.valid=1 for 0x80000100, then at cycle 2 change addr to 0x80000200. The first fill completes, no data_ok for 0x80000100, then a fill for 0x80000200 follows.
- Async reset mid-fill: pull reset low during beat 2 without a clock edge. Outputs go 0 immediately. After release, a request to the same line misses (buf_valid=0).
